// File: rtl/immgen_stage.sv
// Registered immediate-generation stage: decodes RV instruction immediates on the way in
// and buffers the decoded result in a 2-entry valid/ready FIFO.
module immgen_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("immgen_stage: XLEN must be 32 or 64");
    end
  endgenerate

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [6:0]      opc;
  logic [2:0]      funct3;

  assign opc    = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // Sign-extension is done by pre-filling with instr[31] and overwriting the low field.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opc)
      7'b0000011, 7'b1100111: begin
        dec_fmt       = FMT_I;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[11:0] = in_instr[31:20];
      end
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (XLEN == 32) begin
            if (in_instr[25]) begin
              dec_ill = 1'b1;
            end else begin
              dec_fmt      = FMT_SH;
              dec_imm[4:0] = in_instr[24:20];
            end
          end else begin
            dec_fmt      = FMT_SH;
            dec_imm[5:0] = in_instr[25:20];
          end
        end else begin
          dec_fmt       = FMT_I;
          dec_imm       = {XLEN{in_instr[31]}};
          dec_imm[11:0] = in_instr[31:20];
        end
      end
      7'b0100011: begin
        dec_fmt       = FMT_S;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[11:0] = {in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt       = FMT_B;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt       = FMT_U;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[31:0] = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt       = FMT_J;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011, 7'b0001111, 7'b1110011: dec_fmt = FMT_NONE;
      default: dec_ill = 1'b1;
    endcase
  end

  logic [1:0][31:0]     instr_q, instr_d;
  logic [1:0][XLEN-1:0] imm_q, imm_d;
  logic [1:0][2:0]      fmt_q, fmt_d;
  logic [1:0]           ill_q, ill_d;
  logic [1:0]           count_q, count_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    instr_d  = instr_q;
    imm_d    = imm_q;
    fmt_d    = fmt_q;
    ill_d    = ill_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      // Realign pointers so the next push lands at the head.
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = in_instr;
        imm_d[wr_ptr_q]   = dec_imm;
        fmt_d[wr_ptr_q]   = dec_fmt;
        ill_d[wr_ptr_q]   = dec_ill;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      imm_q    <= '0;
      fmt_q    <= '0;
      ill_q    <= '0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      fmt_q    <= fmt_d;
      ill_q    <= ill_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Head fields read as zero whenever nothing is buffered.
  assign out_instr   = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_imm     = out_valid ? imm_q[rd_ptr_q]   : '0;
  assign out_fmt     = out_valid ? fmt_q[rd_ptr_q]   : FMT_NONE;
  assign out_illegal = out_valid ? ill_q[rd_ptr_q]   : 1'b0;

endmodule

// File: tb/tb_immgen_stage.sv
// Bench for immgen_stage: XLEN=32 and XLEN=64 instances driven in lockstep and
// compared against a queue-based model with an arithmetic immediate decoder.
module tb_immgen_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_instr, a_out_imm;
  logic [2:0]  a_out_fmt;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_instr;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  immgen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instr(a_out_instr), .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal));

  immgen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_instr(b_out_instr), .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: immediate as a plain signed integer, then truncated to XLEN.
  function automatic void ref_dec(input logic [31:0] i, input int xl,
                                  output logic [63:0] imm, output int fmt, output bit ill);
    longint v = 0;
    int f3 = int'(i[14:12]);
    fmt = 0; ill = 0;
    case (i[6:0])
      7'h03, 7'h67: begin fmt = 1; v = longint'(i[30:20]) - (i[31] ? 2048 : 0); end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          if (xl == 32 && i[25]) ill = 1;
          else begin fmt = 6; v = (xl == 32) ? longint'(i[24:20]) : longint'(i[25:20]); end
        end else begin fmt = 1; v = longint'(i[30:20]) - (i[31] ? 2048 : 0); end
      end
      7'h23: begin fmt = 2; v = longint'(i[30:25]) * 32 + longint'(i[11:7]) - (i[31] ? 2048 : 0); end
      7'h63: begin
        fmt = 3;
        v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2 - (i[31] ? 4096 : 0);
      end
      7'h37, 7'h17: begin fmt = 4; v = longint'(i[31:12]) * 4096 - (i[31] ? (longint'(1) << 32) : 0); end
      7'h6F: begin
        fmt = 5;
        v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2
            - (i[31] ? (longint'(1) << 20) : 0);
      end
      7'h33, 7'h0F, 7'h73: fmt = 0;
      default: ill = 1;
    endcase
    imm = 64'(v);
    if (xl == 32) imm = {32'b0, imm[31:0]};
  endfunction

  task automatic check_state();
    logic [63:0] ei; int ef; bit el; logic [31:0] hi;
    bit v = (q.size() > 0);
    chk("valid32", 64'(a_out_valid), 64'(v));
    chk("valid64", 64'(b_out_valid), 64'(v));
    chk("ready32", 64'(a_in_ready), 64'(q.size() < 2));
    chk("ready64", 64'(b_in_ready), 64'(q.size() < 2));
    hi = v ? q[0] : 32'h0;
    chk("instr32", 64'(a_out_instr), 64'(hi));
    chk("instr64", 64'(b_out_instr), 64'(hi));
    ref_dec(hi, 32, ei, ef, el);
    if (!v) begin ei = 0; ef = 0; el = 0; end
    chk("imm32", {32'b0, a_out_imm}, ei);
    chk("fmt32", 64'(a_out_fmt), 64'(ef));
    chk("ill32", 64'(a_out_illegal), 64'(el));
    ref_dec(hi, 64, ei, ef, el);
    if (!v) begin ei = 0; ef = 0; el = 0; end
    chk("imm64", b_out_imm, ei);
    chk("fmt64", 64'(b_out_fmt), 64'(ef));
    chk("ill64", 64'(b_out_illegal), 64'(el));
  endtask

  task automatic sample();
    @(negedge clk);
    check_state();
  endtask

  // Drive inputs for the next rising edge and advance the model across it.
  task automatic drive(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
    bit push, pop;
    in_valid = v; in_instr = ins; out_ready = rdy; flush = fl;
    push = v && (q.size() < 2);
    pop  = rdy && (q.size() > 0);
    if (fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(ins);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
    sample();
    drive(v, ins, rdy, fl);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    check_state();
    in_valid = 0; flush = 0; out_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm32, imm64;
    int          fmt32, fmt64;
    bit          ill32, ill64;
  } vec_t;

  vec_t tbl[$];
  logic [6:0] legal_ops[11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                                7'h6F, 7'h33, 7'h0F, 7'h73};

  initial begin
    tbl.push_back('{32'hFFF02003, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 1, 0, 0});
    tbl.push_back('{32'hE0000FE3, 64'hFFFFFE1E, 64'hFFFFFFFFFFFFFE1E, 3, 3, 0, 0});
    tbl.push_back('{32'hFFFFF06F, 64'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 5, 5, 0, 0});
    tbl.push_back('{32'h800000B7, 64'h80000000, 64'hFFFFFFFF80000000, 4, 4, 0, 0});
    tbl.push_back('{32'h03F09093, 64'h0,        64'd63,               0, 6, 1, 0});
    tbl.push_back('{32'h4050D093, 64'd5,        64'd5,                6, 6, 0, 0});
    tbl.push_back('{32'hFE112E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 2, 2, 0, 0});
    tbl.push_back('{32'h002081B3, 64'h0,        64'h0,                0, 0, 0, 0});
    tbl.push_back('{32'h00000000, 64'h0,        64'h0,                0, 0, 1, 1});

    rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0;
    repeat (2) @(negedge clk);
    check_state();
    rst_n = 1'b1;

    // Known vectors: one push from empty, head checked one cycle later.
    foreach (tbl[k]) begin
      sample();
      drive(1, tbl[k].instr, 1, 0);
      sample();
      chk("tbl_valid", 64'(a_out_valid & b_out_valid), 64'd1);
      chk("tbl_imm32", {32'b0, a_out_imm}, tbl[k].imm32);
      chk("tbl_imm64", b_out_imm, tbl[k].imm64);
      chk("tbl_fmt32", 64'(a_out_fmt), 64'(tbl[k].fmt32));
      chk("tbl_fmt64", 64'(b_out_fmt), 64'(tbl[k].fmt64));
      chk("tbl_ill32", 64'(a_out_illegal), 64'(tbl[k].ill32));
      chk("tbl_ill64", 64'(b_out_illegal), 64'(tbl[k].ill64));
      drive(0, 0, 1, 0);
    end

    // Back-pressure: A,B accepted, C held until space opens, then all drain in order.
    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00200113, 0, 0);
    step(1, 32'h00300193, 0, 0);
    step(1, 32'h00300193, 0, 0);
    sample();
    chk("full_ready", 64'(a_in_ready | b_in_ready), 64'd0);
    drive(1, 32'h00300193, 1, 0);
    step(1, 32'h00300193, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Streaming at one per cycle with count held at 1.
    step(1, 32'h0040A203, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 32'h00000017 | (k << 12), 1, 0);
    step(0, 0, 1, 0);

    // Flush while full with a concurrent push: everything dropped.
    step(1, 32'h00500293, 0, 0);
    step(1, 32'h00600313, 0, 0);
    step(1, 32'h00700393, 1, 1);
    sample();
    chk("flush_valid", 64'(a_out_valid | b_out_valid), 64'd0);
    chk("flush_ready", 64'(a_in_ready & b_in_ready), 64'd1);
    drive(1, 32'h00800413, 1, 0);
    step(0, 0, 1, 0);

    // Async reset mid-stream.
    step(1, 32'h00900493, 0, 0);
    step(1, 32'h00A00513, 0, 0);
    reset_pulse();
    step(1, 32'h00B00593, 1, 0);

    // Random traffic sweeping every opcode plus a bias toward legal ones.
    for (int k = 0; k < 1024; k++) begin
      logic [31:0] ins = $urandom;
      if (k < 512) ins[6:0] = 7'(k % 128);
      else if ($urandom_range(1, 0)) ins[6:0] = legal_ops[$urandom_range(10, 0)];
      step($urandom_range(3, 0) != 0, ins, $urandom_range(3, 0) != 0, $urandom_range(40, 0) == 0);
      if (k == 700) reset_pulse();
    end
    sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
